// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder and its register bank.
package spi_cmd_pkg;

   localparam int ADDR_W     = 7;
   localparam int CMD_WR_BIT = 7;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      READ,
      DISCARD
   } state_e;

endpackage

// File: rtl/spi_cmd_regfile.sv
// NUM_REGS x 8 register bank: one synchronous write port, one combinational
// read port, and the whole bank exposed as a flat vector.
module spi_cmd_regfile
   import spi_cmd_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [7:0]  RST_VAL  = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [7:0]            wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [7:0]            rdata_o,
   output logic [NUM_REGS*8-1:0] regs_flat_o
);

   logic [7:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RST_VAL;
         end
      end else if (we_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr_i == ADDR_W'(i)) begin
               regs_q[i] <= wdata_i;
            end
         end
      end
   end

   // Explicit address compare keeps out-of-range indices harmless for any NUM_REGS.
   always_comb begin
      rdata_o = RST_VAL;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (raddr_i == ADDR_W'(i)) begin
            rdata_o = regs_q[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat_o[8*g +: 8] = regs_q[g];
   end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frames bytes received by spi_slave into register read/write transactions
// and supplies the next read byte back to the slave.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [7:0]  RST_VAL  = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ss,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic [7:0]            tx_byte,
   output logic                  wr_strobe,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  err
);

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < 8'(NUM_REGS));
   endfunction

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
   endfunction

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]          tx_q, tx_d;
   logic                err_q, err_d;
   logic                wr_strobe_q;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                ss_meta_q, ss_s_q, ss_prev_q;
   logic                ss_fall, ss_rise;
   logic                we;
   logic [ADDR_W-1:0]   rd_addr;
   logic [7:0]          rd_data;

   // Synchroniser resets low so a pin still held low across reset is not
   // mistaken for a new frame start; a spurious rise in IDLE is harmless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_meta_q <= 1'b0;
         ss_s_q    <= 1'b0;
         ss_prev_q <= 1'b0;
      end else begin
         ss_meta_q <= ss;
         ss_s_q    <= ss_meta_q;
         ss_prev_q <= ss_s_q;
      end
   end

   assign ss_fall = ss_prev_q & ~ss_s_q;
   assign ss_rise = ~ss_prev_q & ss_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         tx_q        <= RST_VAL;
         err_q       <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         tx_q        <= tx_d;
         err_q       <= err_d;
         wr_strobe_q <= we;
         wr_addr_q   <= wr_addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tx_d      = tx_q;
      err_d     = err_q;
      we        = 1'b0;
      wr_addr_d = wr_addr_q;
      rd_addr   = next_ptr(ptr_q);
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = CMD;
               err_d   = 1'b0;
            end
         end
         CMD: begin
            rd_addr = rx_byte[ADDR_W-1:0];
            if (rx_valid) begin
               if (!addr_ok(rx_byte[ADDR_W-1:0])) begin
                  err_d   = 1'b1;
                  state_d = DISCARD;
               end else begin
                  ptr_d = rx_byte[ADDR_W-1:0];
                  if (rx_byte[CMD_WR_BIT]) begin
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                     tx_d    = rd_data;
                  end
               end
            end
         end
         WRITE: begin
            if (rx_valid) begin
               we        = 1'b1;
               wr_addr_d = ptr_q;
               ptr_d     = next_ptr(ptr_q);
            end
         end
         READ: begin
            if (rx_valid) begin
               ptr_d = next_ptr(ptr_q);
               tx_d  = rd_data;
            end
         end
         DISCARD: ;
         default: state_d = IDLE;
      endcase
      // The byte arriving with the frame-end edge is still acted on above.
      if (state_q != IDLE && ss_rise) begin
         state_d = IDLE;
      end
   end

   spi_cmd_regfile #(
      .NUM_REGS (NUM_REGS),
      .RST_VAL  (RST_VAL)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we),
      .waddr_i     (ptr_q),
      .wdata_i     (rx_byte),
      .raddr_i     (rd_addr),
      .rdata_o     (rd_data),
      .regs_flat_o (regs_flat)
   );

   assign tx_byte   = tx_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomised and directed bench for spi_cmd_decoder against a frame-level model.
module tb_spi_cmd_decoder;

   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ss = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic [7:0]    tx_byte;
   logic          wr_strobe;
   logic [6:0]    wr_addr;
   logic [NR*8-1:0] regs_flat;
   logic          err;

   spi_cmd_decoder #(.NUM_REGS(NR), .RST_VAL(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .ss        (ss),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .tx_byte   (tx_byte),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .regs_flat (regs_flat),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_strobe = 0;
   bit chk_on = 0;

   // Frame-level model: register array, read/write pointer and byte index.
   logic [7:0] m_regs [NR];
   logic [7:0] m_tx;
   logic       m_strobe;
   logic [6:0] m_waddr;
   logic       m_err;
   int         m_mask;
   bit         in_frame;
   int         m_idx;
   int         m_mode;   // 1 write, 2 read, 3 discard
   int         m_ptr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      m_tx = 8'h00; m_strobe = 0; m_waddr = 7'd0; m_err = 0; m_mask = 0;
      in_frame = 0; m_idx = 0; m_mode = 0; m_ptr = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_idx == 0) begin
         if (int'(b[6:0]) >= NR) begin
            m_err = 1; m_mode = 3;
         end else begin
            m_ptr = int'(b[6:0]);
            if (b[7]) m_mode = 1;
            else begin m_mode = 2; m_tx = m_regs[m_ptr]; end
         end
      end else if (m_mode == 1) begin
         m_regs[m_ptr] = b; m_strobe = 1; m_waddr = 7'(m_ptr);
         m_ptr = (m_ptr + 1) % NR;
      end else if (m_mode == 2) begin
         m_ptr = (m_ptr + 1) % NR;
         m_tx = m_regs[m_ptr];
      end
      m_idx++;
   endtask

   // Per-cycle compare, 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), 32'(regs_flat[8*i +: 8]), 32'(m_regs[i]));
         chk("tx_byte", 32'(tx_byte), 32'(m_tx));
         chk("wr_strobe", 32'(wr_strobe), 32'(m_strobe));
         if (m_strobe) chk("wr_addr", 32'(wr_addr), 32'(m_waddr));
         if (m_mask > 0) m_mask--;
         else chk("err", 32'(err), 32'(m_err));
         if (wr_strobe === 1'b1) n_strobe++;
      end
   end

   task automatic step(input logic v, input logic [7:0] b);
      @(posedge clk); #2;
      rx_valid = v; rx_byte = b;
      m_strobe = 0;
      if (v && in_frame) model_byte(b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic ss_drive(input logic level);
      @(posedge clk); #2;
      ss = level; rx_valid = 0; m_strobe = 0;
      if (!level) begin
         in_frame = 1; m_idx = 0; m_mode = 0; m_err = 0; m_mask = 3;
      end
   endtask

   task automatic frame_open();
      ss_drive(1'b0);
      idle(4);
   endtask

   task automatic frame_close();
      ss_drive(1'b1);
      idle(4);
      in_frame = 0;
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b);
      idle(1);
   endtask

   int s0;

   initial begin
      model_reset();
      rst = 1;
      @(posedge clk); #2;
      chk_on = 1;
      chk("rst_tx", 32'(tx_byte), 32'h00);
      chk("rst_wr_addr", 32'(wr_addr), 32'h00);
      chk("rst_regs", 32'(regs_flat == '0), 32'h1);
      idle(1);
      rst = 0;
      idle(3);

      // Write frame
      s0 = n_strobe;
      frame_open();
      send(8'h83); send(8'hAA); send(8'hBB);
      frame_close();
      chk("t1_reg3", 32'(regs_flat[8*3 +: 8]), 32'hAA);
      chk("t1_reg4", 32'(regs_flat[8*4 +: 8]), 32'hBB);
      chk("t1_strobes", 32'(n_strobe - s0), 32'd2);
      chk("t1_err", 32'(err), 32'h0);

      // Read frame after preload
      frame_open();
      send(8'h85); send(8'h5C); send(8'h6D);
      frame_close();
      s0 = n_strobe;
      frame_open();
      step(1'b1, 8'h05); idle(1);
      chk("t2_tx_cmd", 32'(tx_byte), 32'h5C);
      step(1'b1, 8'hFF); idle(1);
      chk("t2_tx_d1", 32'(tx_byte), 32'h6D);
      send(8'h00);
      frame_close();
      chk("t2_strobes", 32'(n_strobe - s0), 32'd0);

      // Pointer wrap
      frame_open();
      send(8'h8F); send(8'h11); send(8'h22);
      frame_close();
      chk("t3_reg15", 32'(regs_flat[8*15 +: 8]), 32'h11);
      chk("t3_reg0", 32'(regs_flat[8*0 +: 8]), 32'h22);

      // Bad address
      s0 = n_strobe;
      frame_open();
      send(8'h90); send(8'h77);
      frame_close();
      chk("t4_err_set", 32'(err), 32'h1);
      chk("t4_strobes", 32'(n_strobe - s0), 32'd0);
      frame_open();
      chk("t4_err_clr", 32'(err), 32'h0);
      frame_close();

      // Edge cases
      send(8'h8A);
      send(8'h33);
      chk("t5_idle_ignored", 32'(regs_flat[8*10 +: 8]), 32'h00);
      frame_open();
      send(8'h87);
      ss_drive(1'b1);
      step(1'b0, 8'h00);
      step(1'b1, 8'h34);
      in_frame = 0;
      idle(4);
      chk("t5_rise_write", 32'(regs_flat[8*7 +: 8]), 32'h34);
      frame_open();
      send(8'h89);
      frame_close();
      chk("t5_cmd_only", 32'(regs_flat[8*9 +: 8]), 32'h00);

      // Reset mid-write frame
      frame_open();
      send(8'h82); send(8'h11);
      @(posedge clk); #2;
      rst = 1; rx_valid = 0;
      model_reset();
      idle(2);
      @(posedge clk); #2;
      rst = 0;
      send(8'h8C); send(8'h44);
      chk("t6_regs", 32'(regs_flat == '0), 32'h1);
      chk("t6_tx", 32'(tx_byte), 32'h00);
      frame_close();

      // Randomised frames
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) send(8'($urandom));
         frame_open();
         begin
            logic [7:0] cmd;
            int nb;
            cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
            nb = $urandom_range(0, 5);
            step(1'b1, cmd);
            idle($urandom_range(1, 2));
            for (int k = 0; k < nb; k++) begin
               step(1'b1, 8'($urandom));
               idle($urandom_range(1, 2));
            end
         end
         frame_close();
      end

      idle(2);
      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
